// File: rtl/pwm_peripheral_pkg.sv
// Shared definitions for the PWM peripheral: register offsets, alignment
// encodings, period length, reset divider and the duty clamp helper.
package pwm_peripheral_pkg;

  localparam logic [3:0] OFF_DIV  = 4'h0;
  localparam logic [3:0] OFF_DUTY = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;

  typedef enum logic [1:0] {
    AlignLeft    = 2'd0,
    AlignCenter  = 2'd1,
    AlignRight   = 2'd2,
    AlignLeftAlt = 2'd3   // behaves as left
  } align_e;

  localparam int unsigned PWM_STEPS   = 100;
  localparam logic [15:0] DIV_RESET   = 16'd100;
  localparam int unsigned CTRL_EN_BIT = 31;

  // Duty is stored raw; anything above a full period saturates to 100 %.
  function automatic logic [7:0] clamp_duty(input logic [7:0] duty);
    return (duty > 8'(PWM_STEPS)) ? 8'(PWM_STEPS) : duty;
  endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM engine: prescaler, 100-step period counter, duty clamp and comparator.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   enable           - run/hold; when low both counters sit at 0 and output is 0
//   div              - raw divider (0 and 1 treated as 2)
//   duty             - raw duty in percent (clamped to 100)
//   align            - 0 left, 1 center, 2 right, 3 left
//   clear_prescaler  - restart the prescaler (divider rewritten)
//   pwm_out          - registered PWM output
//   pwm_tick, pwm_counter, safe_duty_cycle, pwm_align - internal state for probing
module pwm_core
  import pwm_peripheral_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] div,
  input  logic [7:0]  duty,
  input  logic [1:0]  align,
  input  logic        clear_prescaler,
  output logic        pwm_out,
  output logic        pwm_tick,
  output logic [6:0]  pwm_counter,
  output logic [7:0]  safe_duty_cycle,
  output align_e      pwm_align
);

  localparam logic [6:0] CountLast = 7'(PWM_STEPS - 1);

  logic [15:0] div_eff;
  logic [15:0] prescaler_q, prescaler_d;
  logic [6:0]  counter_q, counter_d;
  logic        pwm_out_q, pwm_out_d;
  logic [7:0]  count_ext;
  logic [7:0]  center_start;
  logic        cmp_high;

  always_comb begin
    div_eff         = (div < 16'd2) ? 16'd2 : div;
    safe_duty_cycle = clamp_duty(duty);
    pwm_align       = align_e'(align);
    // >= keeps the prescaler bounded should it ever sit above the divider
    pwm_tick        = enable && !clear_prescaler && (prescaler_q >= div_eff - 16'd1);

    prescaler_d = prescaler_q + 16'd1;
    counter_d   = counter_q;
    if (!enable) begin
      prescaler_d = '0;
      counter_d   = '0;
    end else if (clear_prescaler) begin
      prescaler_d = '0;
    end else if (pwm_tick) begin
      prescaler_d = '0;
      counter_d   = (counter_q == CountLast) ? '0 : counter_q + 7'd1;
    end
  end

  always_comb begin
    count_ext    = {1'b0, counter_q};
    center_start = (8'(PWM_STEPS) - safe_duty_cycle) >> 1;
    case (pwm_align)
      AlignCenter: cmp_high = (count_ext >= center_start) &&
                              (count_ext < center_start + safe_duty_cycle);
      AlignRight:  cmp_high = (count_ext >= 8'(PWM_STEPS) - safe_duty_cycle);
      default:     cmp_high = (count_ext < safe_duty_cycle);
    endcase
    pwm_out_d = enable && cmp_high;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      counter_q   <= '0;
      pwm_out_q   <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      counter_q   <= counter_d;
      pwm_out_q   <= pwm_out_d;
    end
  end

  assign pwm_counter = counter_q;
  assign pwm_out     = pwm_out_q;

endmodule

// File: rtl/pwm_peripheral.sv
// Memory-mapped single-channel PWM peripheral: bus handshake, register file
// (DIV, DUTY, CTRL) and one pwm_core instance.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   add, din, mask        - byte address, write data, write byte enables
//   wr, rd                - one-cycle requests
//   wr_strobe, rd_strobe  - master acknowledges closing a transaction
//   wr_busy, rd_busy      - transaction open flags
//   dout                  - read data, held until the next read
//   pwm_out               - registered PWM output
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] add,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        wr,
  input  logic        rd,
  output logic        wr_busy,
  output logic        rd_busy,
  input  logic        wr_strobe,
  input  logic        rd_strobe,
  input  logic [3:0]  mask,
  output logic        pwm_out
);

  logic [15:0] div_q, div_d;
  logic [7:0]  duty_q, duty_d;
  logic        ctrl_en_q, ctrl_en_d;
  logic [1:0]  ctrl_align_q, ctrl_align_d;
  logic        clear_prescaler;

  // Only the data/mask bits that map onto real register fields are latched.
  logic        wr_pend_q, wr_busy_q;
  logic [31:0] wr_addr_q;
  logic [15:0] wr_data_q;
  logic        wr_data_en_q;
  logic [2:0]  wr_mask_q;   // {mask[3], mask[1], mask[0]}
  logic        rd_pend_q, rd_busy_q;
  logic [31:0] rd_addr_q;
  logic [31:0] dout_q, rdata;
  logic        wr_accept, rd_accept;
  logic        unused_bits;

  assign unused_bits = ^{din[30:16], mask[2]};

  // A new request is refused while the previous one is latched or still open.
  assign wr_accept = wr && !wr_pend_q && !wr_busy_q;
  assign rd_accept = rd && !rd_pend_q && !rd_busy_q;

  always_comb begin
    div_d           = div_q;
    duty_d          = duty_q;
    ctrl_en_d       = ctrl_en_q;
    ctrl_align_d    = ctrl_align_q;
    clear_prescaler = 1'b0;
    if (wr_pend_q && (wr_addr_q[31:4] == BASE_ADDR[31:4])) begin
      case (wr_addr_q[3:0])
        OFF_DIV: begin
          if (wr_mask_q[0]) div_d[7:0]  = wr_data_q[7:0];
          if (wr_mask_q[1]) div_d[15:8] = wr_data_q[15:8];
          clear_prescaler = 1'b1;
        end
        OFF_DUTY: begin
          if (wr_mask_q[0]) duty_d = wr_data_q[7:0];
        end
        OFF_CTRL: begin
          if (wr_mask_q[0]) ctrl_align_d = wr_data_q[1:0];
          if (wr_mask_q[2]) ctrl_en_d    = wr_data_en_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_addr_q[31:4] == BASE_ADDR[31:4]) begin
      case (rd_addr_q[3:0])
        OFF_DIV:  rdata = {16'h0, div_q};
        OFF_DUTY: rdata = {24'h0, duty_q};
        OFF_CTRL: begin
          rdata[CTRL_EN_BIT] = ctrl_en_q;
          rdata[1:0]         = ctrl_align_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= DIV_RESET;
      duty_q       <= '0;
      ctrl_en_q    <= 1'b0;
      ctrl_align_q <= '0;
      wr_pend_q    <= 1'b0;
      wr_busy_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_data_en_q <= 1'b0;
      wr_mask_q    <= '0;
      rd_pend_q    <= 1'b0;
      rd_busy_q    <= 1'b0;
      rd_addr_q    <= '0;
      dout_q       <= '0;
    end else begin
      div_q        <= div_d;
      duty_q       <= duty_d;
      ctrl_en_q    <= ctrl_en_d;
      ctrl_align_q <= ctrl_align_d;

      wr_pend_q <= wr_accept;
      if (wr_accept) begin
        wr_addr_q    <= add;
        wr_data_q    <= din[15:0];
        wr_data_en_q <= din[CTRL_EN_BIT];
        wr_mask_q    <= {mask[3], mask[1:0]};
      end
      if (wr_pend_q)                   wr_busy_q <= 1'b1;
      else if (wr_busy_q && wr_strobe) wr_busy_q <= 1'b0;

      rd_pend_q <= rd_accept;
      if (rd_accept) rd_addr_q <= add;
      // rdata reflects the registers before any write landing on this edge.
      if (rd_pend_q) dout_q <= rdata;
      if (rd_pend_q)                   rd_busy_q <= 1'b1;
      else if (rd_busy_q && rd_strobe) rd_busy_q <= 1'b0;
    end
  end

  assign dout    = dout_q;
  assign wr_busy = wr_busy_q;
  assign rd_busy = rd_busy_q;

  pwm_core u_core (
    .clk             (clk),
    .rst             (rst),
    .enable          (ctrl_en_q),
    .div             (div_q),
    .duty            (duty_q),
    .align           (ctrl_align_q),
    .clear_prescaler (clear_prescaler),
    .pwm_out         (pwm_out),
    .pwm_tick        (),
    .pwm_counter     (),
    .safe_duty_cycle (),
    .pwm_align       ()
  );

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: bus handshake, register map, PWM
// waveforms against a period/duty reference model, divider and reset checks.
module tb_pwm_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] add, din, dout;
  logic        wr, rd, wr_busy, rd_busy, wr_strobe, rd_strobe;
  logic [3:0]  mask;
  logic        pwm_out;

  int n_checks;
  int n_fails;

  pwm_peripheral #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .add       (add),
    .din       (din),
    .dout      (dout),
    .wr        (wr),
    .rd        (rd),
    .wr_busy   (wr_busy),
    .rd_busy   (rd_busy),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .mask      (mask),
    .pwm_out   (pwm_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int div_eff(input int dv);
    return (dv < 2) ? 2 : dv;
  endfunction

  function automatic bit model_high(input int align, input int duty, input int cnt);
    int d, s;
    d = (duty > 100) ? 100 : duty;
    if (align == 1) begin
      s = (100 - d) / 2;
      return (cnt >= s) && (cnt < s + d);
    end else if (align == 2) begin
      return cnt >= 100 - d;
    end
    return cnt < d;
  endfunction

  // ---------------- bus drivers ----------------
  // Returns on the falling edge one cycle after the register update.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk); wr = 1'b1; add = a; din = d; mask = m;
    @(posedge clk);
    @(negedge clk); wr = 1'b0;
    @(posedge clk);
    @(negedge clk); wr_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk); wr_strobe = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] data, output logic busy);
    @(negedge clk); rd = 1'b1; add = a;
    @(posedge clk);
    @(negedge clk); rd = 1'b0;
    @(posedge clk);
    @(negedge clk); data = dout; busy = rd_busy; rd_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk); rd_strobe = 1'b0;
  endtask

  // Programs a fresh run and compares every cycle against the model; counts as one check.
  task automatic run_wave(input int dv, input int duty, input int align, input int cycles,
                          input string name);
    int n, de, bad, e_cnt, f_n;
    bit e_out;
    logic f_out;
    int f_cnt, f_ecnt;
    bit f_eout;
    de = div_eff(dv);
    bus_write(BASE + 32'h8, 32'h0, 4'hF);
    bus_write(BASE + 32'h0, 32'(dv), 4'hF);
    bus_write(BASE + 32'h4, 32'(duty), 4'hF);
    bus_write(BASE + 32'h8, 32'h8000_0000 | 32'(align), 4'hF);
    n = 1; bad = 0; f_n = 0; f_out = 0; f_cnt = 0; f_ecnt = 0; f_eout = 0;
    for (int i = 0; i < cycles; i++) begin
      e_cnt = (n / de) % 100;
      e_out = model_high(align, duty, ((n - 1) / de) % 100);
      if (pwm_out !== e_out || int'(dut.u_core.pwm_counter) != e_cnt) begin
        if (bad == 0) begin
          f_n = n; f_out = pwm_out; f_cnt = int'(dut.u_core.pwm_counter);
          f_eout = e_out; f_ecnt = e_cnt;
        end
        bad++;
      end
      @(posedge clk); @(negedge clk); n++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL %s (div=%0d duty=%0d align=%0d): %0d bad cycles, first n=%0d got out=%b cnt=%0d need out=%b cnt=%0d",
               name, dv, duty, align, bad, f_n, f_out, f_cnt, f_eout, f_ecnt);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] r; logic b;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_checks++;
    if (dout !== 32'h0 || wr_busy !== 1'b0 || rd_busy !== 1'b0 || pwm_out !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: got dout=%h wr_busy=%b rd_busy=%b pwm=%b need 0/0/0/0",
               dout, wr_busy, rd_busy, pwm_out);
    end
    n_checks++;
    if (dut.u_core.pwm_counter !== 7'd0) begin
      n_fails++; $display("FAIL reset_counter: got %0d need 0", dut.u_core.pwm_counter);
    end
    bus_read(BASE + 32'h0, r, b);
    n_checks++;
    if (r !== 32'd100) begin n_fails++; $display("FAIL reset_div: got %h need 64", r); end
    bus_read(BASE + 32'h4, r, b);
    n_checks++;
    if (r !== 32'd0) begin n_fails++; $display("FAIL reset_duty: got %h need 0", r); end
    bus_read(BASE + 32'h8, r, b);
    n_checks++;
    if (r !== 32'd0) begin n_fails++; $display("FAIL reset_ctrl: got %h need 0", r); end
  endtask

  task automatic test_handshake();
    logic [31:0] r; logic b;
    // Write DUTY=50 by hand to watch wr_busy.
    @(negedge clk); wr = 1'b1; add = BASE + 32'h4; din = 32'd50; mask = 4'hF;
    @(posedge clk);
    @(negedge clk); wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wr_busy !== 1'b1) begin n_fails++; $display("FAIL wr_busy_set: got %b need 1", wr_busy); end
    // Write attempt while busy must be dropped.
    wr = 1'b1; din = 32'd99;
    @(posedge clk);
    @(negedge clk); wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wr_busy !== 1'b1) begin n_fails++; $display("FAIL wr_busy_hold: got %b need 1", wr_busy); end
    wr_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk); wr_strobe = 1'b0;
    n_checks++;
    if (wr_busy !== 1'b0) begin n_fails++; $display("FAIL wr_busy_clear: got %b need 0", wr_busy); end

    bus_write(BASE + 32'h0, 32'd100, 4'hF);
    bus_write(BASE + 32'h8, 32'h8000_0001, 4'hF);
    bus_read(BASE + 32'h0, r, b);
    n_checks++;
    if (r !== 32'd100) begin n_fails++; $display("FAIL read_div: got %h need 64", r); end
    n_checks++;
    if (b !== 1'b1 || rd_busy !== 1'b0) begin
      n_fails++; $display("FAIL rd_busy: got during=%b after=%b need 1/0", b, rd_busy);
    end
    bus_read(BASE + 32'h4, r, b);
    n_checks++;
    if (r !== 32'd50) begin n_fails++; $display("FAIL read_duty: got %h need 32", r); end
    bus_read(BASE + 32'h8, r, b);
    n_checks++;
    if (r !== 32'h8000_0001) begin n_fails++; $display("FAIL read_ctrl: got %h need 80000001", r); end

    // Unmapped and unselected accesses.
    bus_read(BASE + 32'hC, r, b);
    n_checks++;
    if (r !== 32'h0) begin n_fails++; $display("FAIL read_unmapped: got %h need 0", r); end
    bus_write(32'h5000_0004, 32'd7, 4'hF);
    bus_read(32'h5000_0000, r, b);
    n_checks++;
    if (r !== 32'h0) begin n_fails++; $display("FAIL read_unselected: got %h need 0", r); end
    bus_read(BASE + 32'h4, r, b);
    n_checks++;
    if (r !== 32'd50) begin n_fails++; $display("FAIL unselected_write: duty got %h need 32", r); end

    // Masked write of low byte only.
    bus_write(BASE + 32'h0, 32'hFFFF_FF20, 4'b0001);
    bus_read(BASE + 32'h0, r, b);
    n_checks++;
    if (r !== 32'h20) begin n_fails++; $display("FAIL masked_div: got %h need 20", r); end

    // Simultaneous write and read of DUTY: the read sees the old value.
    @(negedge clk); wr = 1'b1; rd = 1'b1; add = BASE + 32'h4; din = 32'd77; mask = 4'hF;
    @(posedge clk);
    @(negedge clk); wr = 1'b0; rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dout !== 32'd50) begin n_fails++; $display("FAIL wr_rd_same_cycle: got %h need 32", dout); end
    wr_strobe = 1'b1; rd_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk); wr_strobe = 1'b0; rd_strobe = 1'b0;
    bus_read(BASE + 32'h4, r, b);
    n_checks++;
    if (r !== 32'd77) begin n_fails++; $display("FAIL wr_rd_after: got %h need 4d", r); end
  endtask

  task automatic test_duty_limits();
    logic [31:0] r; logic b;
    run_wave(2, 0, 0, 210, "duty0_left");
    run_wave(2, 0, 1, 210, "duty0_center");
    run_wave(2, 100, 2, 210, "duty100_right");
    run_wave(2, 100, 1, 210, "duty100_center");
    run_wave(3, 150, 0, 310, "duty150_left");
    n_checks++;
    if (dut.u_core.safe_duty_cycle !== 8'd100) begin
      n_fails++; $display("FAIL safe_duty: got %0d need 100", dut.u_core.safe_duty_cycle);
    end
    bus_read(BASE + 32'h4, r, b);
    n_checks++;
    if (r !== 32'd150) begin n_fails++; $display("FAIL duty150_readback: got %0d need 150", r); end
  endtask

  task automatic test_alignment();
    run_wave(100, 25, 0, 5100, "left25_div100");
    run_wave(2, 75, 0, 210, "left75");
    run_wave(2, 30, 1, 210, "center30");
    run_wave(3, 10, 2, 310, "right10");
    run_wave(2, 40, 3, 210, "align3_left40");
  endtask

  task automatic test_random();
    int dv, duty, align;
    for (int k = 0; k < 8; k++) begin
      dv    = int'($urandom_range(0, 4));
      duty  = int'($urandom_range(0, 160));
      align = int'($urandom_range(0, 3));
      run_wave(dv, duty, align, div_eff(dv) * 101 + 5, "random");
    end
  endtask

  task automatic test_enable_off();
    int bad;
    run_wave(2, 50, 0, 60, "pre_disable");
    bus_write(BASE + 32'h8, 32'h0, 4'hF);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (pwm_out !== 1'b0 || dut.u_core.pwm_counter !== 7'd0) bad++;
      @(posedge clk); @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++; $display("FAIL disabled_hold: got %0d active cycles need 0", bad);
    end
    // Re-enable mid-stream restarts from counter 0.
    run_wave(2, 50, 0, 210, "reenable");
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r; logic b;
    run_wave(2, 60, 0, 40, "pre_reset");
    bus_read(BASE + 32'h0, r, b);   // leaves dout non-zero
    @(negedge clk); wr = 1'b1; add = BASE + 32'h4; din = 32'd9; mask = 4'hF;
    @(posedge clk);
    @(negedge clk); wr = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_checks++;
    if (dout !== 32'h0 || wr_busy !== 1'b0 || rd_busy !== 1'b0 || pwm_out !== 1'b0 ||
        dut.u_core.pwm_counter !== 7'd0) begin
      n_fails++;
      $display("FAIL midrun_reset: got dout=%h wb=%b rb=%b pwm=%b cnt=%0d need all 0",
               dout, wr_busy, rd_busy, pwm_out, dut.u_core.pwm_counter);
    end
    bus_read(BASE + 32'h4, r, b);
    n_checks++;
    if (r !== 32'h0) begin n_fails++; $display("FAIL midrun_dropped_write: got %h need 0", r); end
    bus_read(BASE + 32'h0, r, b);
    n_checks++;
    if (r !== 32'd100) begin n_fails++; $display("FAIL midrun_div: got %h need 64", r); end
  endtask

  task automatic test_divider();
    int m, bad;
    int dvs [2] = '{2, 0};
    bus_write(BASE + 32'h8, 32'h8000_0000, 4'hF);
    foreach (dvs[j]) begin
      bus_write(BASE + 32'h0, 32'(dvs[j]), 4'hF);
      m = 1; bad = 0;
      for (int i = 0; i < 20; i++) begin
        if (dut.u_core.pwm_tick !== ((m % div_eff(dvs[j])) == div_eff(dvs[j]) - 1)) bad++;
        @(posedge clk); @(negedge clk); m++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fails++; $display("FAIL tick_div%0d: got %0d wrong cycles need 0", dvs[j], bad);
      end
    end
    bus_write(BASE + 32'h0, 32'h0000_FFFF, 4'hF);
    m = 1;
    while (dut.u_core.pwm_tick !== 1'b1 && m < 70000) begin
      @(posedge clk); @(negedge clk); m++;
    end
    n_checks++;
    if (m != 65534) begin
      n_fails++; $display("FAIL tick_divffff: first tick at %0d need 65534", m);
    end
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    rst = 1'b1; add = '0; din = '0; mask = '0;
    wr = 1'b0; rd = 1'b0; wr_strobe = 1'b0; rd_strobe = 1'b0;
    test_reset();
    test_handshake();
    test_duty_limits();
    test_alignment();
    test_random();
    test_enable_off();
    test_reset_midrun();
    test_divider();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
